// File: rtl/seven_seg_if.sv
// Multiplexed seven-segment link: active-low scan lines from the display driver
// plus the reconstructed four-digit frame reported back by the capture block.
interface seven_seg_if;
    logic [7:0] segments;
    logic [3:0] anodes;
    logic [4:0] digit0;
    logic [4:0] digit1;
    logic [4:0] digit2;
    logic [4:0] digit3;
    logic       frame_done;
    logic       frame_err;
    logic       active;

    modport master (
        output segments, anodes,
        input  digit0, digit1, digit2, digit3, frame_done, frame_err, active
    );

    modport slave (
        input  segments, anodes,
        output digit0, digit1, digit2, digit3, frame_done, frame_err, active
    );
endinterface

// File: rtl/seven_seg_capture.sv
// Rebuilds the four displayed digits from sampled scan lines; capture SETTLE+1 cycles after a stable pattern, publish one cycle later.
// No backpressure: the block is a passive sampler and never stalls the scanning driver.
module seven_seg_capture #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 200000
) (
    input  logic          clk,
    input  logic          rst_n,
    seven_seg_if.slave    bus
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [11:0]      smp;
    logic [SW-1:0]    stab_cnt;
    logic             armed;
    logic [TW-1:0]    idle_cnt;
    logic [3:0][4:0]  shadow;
    logic [3:0]       shadow_err;
    logic [3:0]       seen;

    logic [11:0]      port_smp;
    logic             stable;
    logic             one_hot;
    logic             capture;
    logic             timeout_hit;
    logic [1:0]       cap_idx;
    logic [4:0]       dec;
    logic [3:0]       seen_nxt;
    logic [3:0]       err_nxt;

    // {err, hex}; undecodable patterns report hex 0 with the error bit set
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        case (s)
            7'b1000000: return 5'h00;
            7'b1111001: return 5'h01;
            7'b0100100: return 5'h02;
            7'b0110000: return 5'h03;
            7'b0011001: return 5'h04;
            7'b0010010: return 5'h05;
            7'b0000010: return 5'h06;
            7'b1111000: return 5'h07;
            7'b0000000: return 5'h08;
            7'b0010000: return 5'h09;
            7'b0001000: return 5'h0a;
            7'b0000011: return 5'h0b;
            7'b1000110: return 5'h0c;
            7'b0100001: return 5'h0d;
            7'b0000110: return 5'h0e;
            7'b0001110: return 5'h0f;
            default:    return 5'h10;
        endcase
    endfunction

    // Stability is judged by comparing the incoming value against smp, so the
    // counter reaches SETTLE on the same edge that loads the SETTLE-th stable sample.
    always_comb begin
        port_smp    = {bus.anodes, bus.segments};
        stable      = (port_smp == smp);
        one_hot     = smp[11:8] inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
        capture     = armed && stable && one_hot && (stab_cnt == SW'(SETTLE - 1));
        timeout_hit = !capture && (idle_cnt == TW'(TIMEOUT - 1));
        dec         = decode_seg(smp[6:0]);

        cap_idx = 2'd0;
        case (smp[11:8])
            4'b1101: cap_idx = 2'd1;
            4'b1011: cap_idx = 2'd2;
            4'b0111: cap_idx = 2'd3;
            default: cap_idx = 2'd0;
        endcase

        seen_nxt = seen;
        err_nxt  = shadow_err;
        if (seen == 4'hf || timeout_hit) begin
            seen_nxt = 4'h0;
            err_nxt  = 4'h0;
        end
        if (capture) begin
            seen_nxt[cap_idx] = 1'b1;
            err_nxt[cap_idx]  = dec[4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp            <= 12'hfff;
            stab_cnt       <= '0;
            armed          <= 1'b0;
            idle_cnt       <= '0;
            shadow         <= '0;
            shadow_err     <= 4'h0;
            seen           <= 4'h0;
            bus.digit0     <= 5'h00;
            bus.digit1     <= 5'h00;
            bus.digit2     <= 5'h00;
            bus.digit3     <= 5'h00;
            bus.frame_done <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.active     <= 1'b0;
        end else begin
            smp <= port_smp;
            if (!stable) begin
                stab_cnt <= '0;
                armed    <= 1'b1;
            end else begin
                if (stab_cnt != SW'(SETTLE))
                    stab_cnt <= stab_cnt + 1'b1;
                if (capture)
                    armed <= 1'b0;
            end

            if (capture)
                shadow[cap_idx] <= {~smp[7], dec[3:0]};
            seen       <= seen_nxt;
            shadow_err <= err_nxt;

            bus.frame_done <= 1'b0;
            if (seen == 4'hf) begin
                bus.digit0     <= shadow[0];
                bus.digit1     <= shadow[1];
                bus.digit2     <= shadow[2];
                bus.digit3     <= shadow[3];
                bus.frame_err  <= |shadow_err;
                bus.frame_done <= 1'b1;
            end

            if (capture) begin
                idle_cnt   <= '0;
                bus.active <= 1'b1;
            end else if (idle_cnt != TW'(TIMEOUT)) begin
                idle_cnt <= idle_cnt + 1'b1;
                if (timeout_hit)
                    bus.active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed scan sequences against seven_seg_capture; expected frames are queued
// as each scan is driven and popped by a monitor whenever frame_done pulses.
module tb_seven_seg_capture;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_seg_if bus();

    seven_seg_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int frames = 0;
    int f0;
    logic prev_done = 1'b0;
    logic [20:0] exp_q[$];
    logic [20:0] obs_frame;

    function automatic logic [6:0] enc(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'ha: return 7'b0001000;
            4'hb: return 7'b0000011;
            4'hc: return 7'b1000110;
            4'hd: return 7'b0100001;
            4'he: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [20:0] frm(input logic [4:0] d0, input logic [4:0] d1,
                                         input logic [4:0] d2, input logic [4:0] d3,
                                         input logic err);
        return {d3, d2, d1, d0, err};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [7:0] seg, input int n);
        @(negedge clk);
        bus.anodes   = an;
        bus.segments = seg;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic show(input int idx, input logic [3:0] h, input logic dp, input int n);
        logic [3:0] an;
        an = 4'hf;
        an[idx] = 1'b0;
        drive(an, {~dp, enc(h)}, n);
    endtask

    task automatic blank(input int n);
        drive(4'hf, 8'hff, n);
    endtask

    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) begin
            frames++;
            obs_frame = {bus.digit3, bus.digit2, bus.digit1, bus.digit0, bus.frame_err};
            if (prev_done) check("frame_done_width", 32'(prev_done), 32'd0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL frame_unexpected: observed %0h expected no frame", obs_frame);
            end else begin
                check("frame_content", 32'(obs_frame), 32'(exp_q.pop_front()));
            end
        end
        prev_done = bus.frame_done;
    end

    initial begin
        bus.anodes   = 4'hf;
        bus.segments = 8'hff;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_digit0", 32'(bus.digit0), 32'd0);
        check("rst_digit3", 32'(bus.digit3), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check("rst_active", 32'(bus.active), 32'd0);
        rst_n = 1'b1;
        blank(3);

        // Basic scan 0,1,2,3 with dp on digit 3
        f0 = frames;
        exp_q.push_back(frm(5'h00, 5'h01, 5'h02, 5'h13, 1'b0));
        show(0, 4'h0, 1'b0, 10);
        show(1, 4'h1, 1'b0, 10);
        show(2, 4'h2, 1'b0, 10);
        show(3, 4'h3, 1'b1, 10);
        blank(5);
        check("basic_frames", 32'(frames), 32'(f0 + 1));
        check("basic_active", 32'(bus.active), 32'd1);
        check("basic_digit3", 32'(bus.digit3), 32'h13);

        // Dwell of exactly SETTLE never captures
        f0 = frames;
        show(0, 4'h5, 1'b0, SETTLE);
        show(1, 4'h6, 1'b0, SETTLE);
        show(2, 4'h7, 1'b0, SETTLE);
        show(3, 4'h8, 1'b0, SETTLE);
        blank(10);
        check("short_dwell_frames", 32'(frames), 32'(f0));

        // Dwell of SETTLE+1 is the minimum that captures
        exp_q.push_back(frm(5'h05, 5'h06, 5'h07, 5'h08, 1'b0));
        show(0, 4'h5, 1'b0, SETTLE + 1);
        show(1, 4'h6, 1'b0, SETTLE + 1);
        show(2, 4'h7, 1'b0, SETTLE + 1);
        show(3, 4'h8, 1'b0, SETTLE + 1);
        blank(10);
        check("min_dwell_frames", 32'(frames), 32'(f0 + 1));

        // Undecodable digit 2, then a clean frame clears the error
        f0 = frames;
        exp_q.push_back(frm(5'h09, 5'h04, 5'h00, 5'h0c, 1'b1));
        show(0, 4'h9, 1'b0, 10);
        show(1, 4'h4, 1'b0, 10);
        drive(4'b1011, 8'hff, 10);
        show(3, 4'hc, 1'b0, 10);
        blank(5);
        check("err_frame_err", 32'(bus.frame_err), 32'd1);
        exp_q.push_back(frm(5'h0a, 5'h0b, 5'h1c, 5'h0d, 1'b0));
        show(0, 4'ha, 1'b0, 10);
        show(1, 4'hb, 1'b0, 10);
        show(2, 4'hc, 1'b1, 10);
        show(3, 4'hd, 1'b0, 10);
        blank(5);
        check("clean_frame_err", 32'(bus.frame_err), 32'd0);
        check("err_frames", 32'(frames), 32'(f0 + 2));

        // Multi-low and blank anode patterns between digits are ignored
        f0 = frames;
        exp_q.push_back(frm(5'h01, 5'h02, 5'h03, 5'h04, 1'b0));
        show(0, 4'h1, 1'b0, 10);
        drive(4'b1100, {1'b1, enc(4'h8)}, 50);
        show(1, 4'h2, 1'b0, 10);
        drive(4'b1111, {1'b0, enc(4'h8)}, 50);
        show(2, 4'h3, 1'b0, 10);
        drive(4'b1100, {1'b0, enc(4'h6)}, 50);
        show(3, 4'h4, 1'b0, 10);
        blank(5);
        check("ignore_frames", 32'(frames), 32'(f0 + 1));

        // Stall after two captures: active drops exactly TIMEOUT cycles later
        f0 = frames;
        show(0, 4'h7, 1'b0, 10);
        show(1, 4'h7, 1'b0, SETTLE + 1);
        blank(TIMEOUT);
        check("timeout_active_before", 32'(bus.active), 32'd1);
        @(negedge clk);
        check("timeout_active_after", 32'(bus.active), 32'd0);
        check("timeout_frames", 32'(frames), 32'(f0));
        // Partial frame was discarded: digits 2,3 alone must not complete it
        show(2, 4'ha, 1'b0, 10);
        show(3, 4'hb, 1'b0, 10);
        blank(10);
        check("timeout_discard_frames", 32'(frames), 32'(f0));
        check("timeout_reactivate", 32'(bus.active), 32'd1);
        exp_q.push_back(frm(5'h0e, 5'h0f, 5'h0a, 5'h0b, 1'b0));
        show(0, 4'he, 1'b0, 10);
        show(1, 4'hf, 1'b0, 10);
        blank(10);
        check("rescan_frames", 32'(frames), 32'(f0 + 1));

        // Asynchronous reset mid-frame after three captures
        show(0, 4'h7, 1'b0, 10);
        show(1, 4'h8, 1'b0, 10);
        show(2, 4'h9, 1'b0, 10);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_digit0", 32'(bus.digit0), 32'd0);
        check("arst_digit1", 32'(bus.digit1), 32'd0);
        check("arst_frame_err", 32'(bus.frame_err), 32'd0);
        check("arst_frame_done", 32'(bus.frame_done), 32'd0);
        check("arst_active", 32'(bus.active), 32'd0);
        bus.anodes   = 4'hf;
        bus.segments = 8'hff;
        @(negedge clk);
        rst_n = 1'b1;
        f0 = frames;
        show(3, 4'h5, 1'b0, 10);
        blank(10);
        check("arst_partial_frames", 32'(frames), 32'(f0));
        exp_q.push_back(frm(5'h01, 5'h02, 5'h03, 5'h05, 1'b0));
        show(0, 4'h1, 1'b0, 10);
        show(1, 4'h2, 1'b0, 10);
        show(2, 4'h3, 1'b0, 10);
        blank(10);
        check("arst_full_frames", 32'(frames), 32'(f0 + 1));

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
